// File: rtl/adc_capture_scheduler.sv
// adc_capture_scheduler
//   Owns the ADCCaptureOne trigger of the AD7682 interface. It arbitrates capture
//   requests from a periodic timer and from the host, then pulses the trigger. It
//   waits out the conversion burst and snapshots all four channels as one set.
//
//   Optional feature: define ADC_SCHED_TSTAMP_EN to add a free-running 32-bit clock
//   counter. Its value at trigger rise is presented on snap_tstamp with each snapshot.
//
// Ports
//   clk, reset            system clock; asynchronous active-high reset
//   enable                timer runs and requests are accepted while high
//   period[15:0]          timer period in clk cycles, 0 disables the timer
//   host_req              single-cycle host capture request
//   adc_conv1..4[15:0]    live channel results from the ADC interface
//   adc_capture           trigger to the ADC interface, high PULSE_LEN cycles
//   busy                  high while a capture sequence is in progress
//   snap_ch1..4[15:0]     coherent snapshot of the four channels
//   snap_seq[7:0]         snapshot sequence number (wraps)
//   snap_valid / snap_ack new-snapshot flag and its single-cycle consume strobe
//   overrun / overrun_clr sticky overwrite/drop flag and its clear
//   snap_tstamp[31:0]     (ADC_SCHED_TSTAMP_EN only) trigger-rise timestamp
module adc_capture_scheduler #(
  parameter int unsigned PULSE_LEN   = 4,
  parameter int unsigned SETTLE_LEN  = 1600,
  parameter int unsigned INIT_SETTLE = 2400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] period,
  input  logic        host_req,
  input  logic [15:0] adc_conv1,
  input  logic [15:0] adc_conv2,
  input  logic [15:0] adc_conv3,
  input  logic [15:0] adc_conv4,
  output logic        adc_capture,
  output logic        busy,
  output logic [15:0] snap_ch1,
  output logic [15:0] snap_ch2,
  output logic [15:0] snap_ch3,
  output logic [15:0] snap_ch4,
  output logic [7:0]  snap_seq,
  output logic        snap_valid,
  input  logic        snap_ack,
  output logic        overrun,
  input  logic        overrun_clr
`ifdef ADC_SCHED_TSTAMP_EN
  ,
  output logic [31:0] snap_tstamp
`endif
);

  localparam int unsigned MAX_SETTLE = (INIT_SETTLE > SETTLE_LEN) ? INIT_SETTLE : SETTLE_LEN;
  localparam int unsigned CNT_W      = $clog2(MAX_SETTLE + 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_SETTLE, S_SNAP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_first_done;
  logic             r_host_pend;
  logic             r_tmr_pend;
  logic [15:0]      r_tmr_cnt;
  logic             r_tmr_run;

  logic w_tmr_on, w_tmr_fire, w_start, w_take_host, w_take_tmr;
  logic w_host_left, w_tmr_left, w_host_evt, w_host_drop, w_tmr_drop;
  logic w_snap, w_snap_ovr;

  // The timer counts period cycles per expiry. The first load happens on the
  // cycle after it becomes enabled, so the first expiry is a full period away.
  assign w_tmr_on   = enable && (period != '0);
  assign w_tmr_fire = w_tmr_on && r_tmr_run && (r_tmr_cnt == '0);

  // Host wins a tie. A flag consumed by this cycle's start may be re-armed by a
  // same-cycle request without counting as a drop.
  assign w_start     = (r_state == S_IDLE) && (r_host_pend || r_tmr_pend);
  assign w_take_host = w_start && r_host_pend;
  assign w_take_tmr  = w_start && !r_host_pend;
  assign w_host_left = r_host_pend && !w_take_host;
  assign w_tmr_left  = r_tmr_pend && !w_take_tmr;
  assign w_host_evt  = enable && host_req;
  assign w_host_drop = w_host_evt && w_host_left;
  assign w_tmr_drop  = w_tmr_fire && w_tmr_left;
  assign w_snap      = (r_state == S_SNAP);
  assign w_snap_ovr  = w_snap && snap_valid && !snap_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmr_cnt <= '0;
      r_tmr_run <= 1'b0;
    end else if (!w_tmr_on) begin
      r_tmr_cnt <= '0;
      r_tmr_run <= 1'b0;
    end else if (!r_tmr_run || (r_tmr_cnt == '0)) begin
      r_tmr_cnt <= period - 16'd1;
      r_tmr_run <= 1'b1;
    end else begin
      r_tmr_cnt <= r_tmr_cnt - 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_host_pend <= 1'b0;
      r_tmr_pend  <= 1'b0;
    end else begin
      r_host_pend <= enable && (w_host_left || w_host_evt);
      r_tmr_pend  <= enable && (w_tmr_left || w_tmr_fire);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (w_host_drop || w_tmr_drop || w_snap_ovr) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  // r_cnt counts from trigger rise through TRIG and SETTLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_first_done <= 1'b0;
      adc_capture  <= 1'b0;
      busy         <= 1'b0;
      snap_ch1     <= '0;
      snap_ch2     <= '0;
      snap_ch3     <= '0;
      snap_ch4     <= '0;
      snap_seq     <= '0;
      snap_valid   <= 1'b0;
    end else begin
      if (snap_ack) snap_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state     <= S_TRIG;
            r_cnt       <= '0;
            adc_capture <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_TRIG: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == PULSE_LAST) begin
            r_state     <= S_SETTLE;
            adc_capture <= 1'b0;
          end
        end
        S_SETTLE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == (r_first_done ? SETTLE_LAST : INIT_LAST)) r_state <= S_SNAP;
        end
        S_SNAP: begin
          snap_ch1     <= adc_conv1;
          snap_ch2     <= adc_conv2;
          snap_ch3     <= adc_conv3;
          snap_ch4     <= adc_conv4;
          snap_seq     <= snap_seq + 8'd1;
          snap_valid   <= 1'b1;
          r_first_done <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ADC_SCHED_TSTAMP_EN
  logic [31:0] r_ts;
  logic [31:0] r_ts_trig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ts        <= '0;
      r_ts_trig   <= '0;
      snap_tstamp <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
      if (w_start) r_ts_trig <= r_ts;
      if (w_snap) snap_tstamp <= r_ts_trig;
    end
  end
`endif

endmodule

// File: tb/tb_adc_capture_scheduler.sv
module tb_adc_capture_scheduler;
  localparam int PULSE  = 4;
  localparam int SETTLE = 1600;
  localparam int INIT   = 2400;

  logic        clk = 1'b0;
  logic        reset, enable, host_req, snap_ack, overrun_clr;
  logic [15:0] period, conv1, conv2, conv3, conv4;
  logic        adc_capture, busy, snap_valid, overrun;
  logic [15:0] snap_ch1, snap_ch2, snap_ch3, snap_ch4;
  logic [7:0]  snap_seq;

  adc_capture_scheduler #(
    .PULSE_LEN(PULSE), .SETTLE_LEN(SETTLE), .INIT_SETTLE(INIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period), .host_req(host_req),
    .adc_conv1(conv1), .adc_conv2(conv2), .adc_conv3(conv3), .adc_conv4(conv4),
    .adc_capture(adc_capture), .busy(busy),
    .snap_ch1(snap_ch1), .snap_ch2(snap_ch2), .snap_ch3(snap_ch3), .snap_ch4(snap_ch4),
    .snap_seq(snap_seq), .snap_valid(snap_valid), .snap_ack(snap_ack),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [7:0]  seq;
    logic [15:0] c1, c2, c3, c4;
    int          edge_n;
    int          lat;
  } snap_t;
  snap_t q_snap[$];

  // Reference model: tracks the capture sequence as edge-number arithmetic.
  // A sequence starting at edge R has its trigger high for edges R..R+PULSE-1.
  // It snapshots at edge R+lim+1 and is idle from that edge on.
  int         m_edge, rise, lim, next_exp;
  bit         hp, tp, act, first_done, tmr_run;
  bit         m_valid, m_over, m_cap, m_busy;
  logic [7:0] m_seq;
  bit         auto_ack;

  int mon_edge;
  always @(posedge clk or posedge reset) begin
    if (reset) mon_edge <= 0;
    else       mon_edge <= mon_edge + 1;
  end

  task automatic model_reset();
    m_edge = 0; rise = 0; lim = 0; next_exp = 0;
    hp = 0; tp = 0; act = 0; first_done = 0; tmr_run = 0;
    m_valid = 0; m_over = 0; m_cap = 0; m_busy = 0; m_seq = 0;
    q_snap.delete();
  endtask

  task automatic model_edge();
    int  e;
    bit  pre_idle, snap_now, start, take_h, take_t, fire, h_evt, hl, tl, drop, ovr_snap;
    snap_t s;
    m_edge++;
    e        = m_edge;
    pre_idle = !act || (e - 1 >= rise + lim + 1);
    snap_now = act && (e == rise + lim + 1);
    start    = pre_idle && (hp || tp);
    take_h   = start && hp;
    take_t   = start && !hp;
    fire     = 0;
    if (enable && period != 0) begin
      if (!tmr_run) begin
        tmr_run  = 1;
        next_exp = e + int'(period);
      end else if (e == next_exp) begin
        fire     = 1;
        next_exp = e + int'(period);
      end
    end else begin
      tmr_run = 0;
    end
    h_evt    = enable && host_req;
    hl       = hp && !take_h;
    tl       = tp && !take_t;
    drop     = (h_evt && hl) || (fire && tl);
    hp       = enable && (hl || h_evt);
    tp       = enable && (tl || fire);
    ovr_snap = snap_now && m_valid && !snap_ack;
    if (snap_now) begin
      m_seq = m_seq + 8'd1;
      s.seq = m_seq; s.c1 = conv1; s.c2 = conv2; s.c3 = conv3; s.c4 = conv4;
      s.edge_n = e; s.lat = lim + 1;
      q_snap.push_back(s);
      first_done = 1;
      m_valid = 1;
    end else if (snap_ack) begin
      m_valid = 0;
    end
    if (drop || ovr_snap) m_over = 1;
    else if (overrun_clr) m_over = 0;
    if (start) begin
      act  = 1;
      rise = e;
      lim  = first_done ? SETTLE : INIT;
    end
    m_cap  = act && (e >= rise) && (e < rise + PULSE);
    m_busy = act && (e < rise + lim + 1);
  endtask

  // One clock: random channel data, optional auto-ack, edge, then clear pulses.
  task automatic tick();
    conv1 = 16'($urandom); conv2 = 16'($urandom);
    conv3 = 16'($urandom); conv4 = 16'($urandom);
    if (auto_ack && m_valid && $urandom_range(0, 3) == 0) snap_ack = 1'b1;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    host_req = 1'b0; snap_ack = 1'b0; overrun_clr = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("reset_adc_capture", adc_capture, 0);
    check("reset_busy", busy, 0);
    check("reset_snap_valid", snap_valid, 0);
    check("reset_overrun", overrun, 0);
    check("reset_snap_seq", snap_seq, 0);
    check("reset_snap_ch1", snap_ch1, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares status flags whenever DUT or model changes, and pops
  // the scoreboard whenever the DUT presents a new snapshot.
  initial begin
    logic [3:0] d, m, prev_d, prev_m;
    logic [7:0] prev_seq;
    logic       prev_cap;
    int         dut_rise;
    snap_t      s;
    prev_d = '0; prev_m = '0; prev_seq = '0; prev_cap = 1'b0; dut_rise = 0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        prev_d = '0; prev_m = '0; prev_seq = '0; prev_cap = 1'b0;
      end else begin
        d = {adc_capture, busy, snap_valid, overrun};
        m = {m_cap, m_busy, m_valid, m_over};
        if (d !== prev_d || m !== prev_m) check("flags_cap_busy_valid_ovr", d, m);
        if (adc_capture === 1'b1 && prev_cap === 1'b0) dut_rise = mon_edge;
        if (snap_seq !== prev_seq) begin
          check("snap_queue_depth", q_snap.size(), 1);
          if (q_snap.size() > 0) begin
            s = q_snap.pop_front();
            check("snap_seq", snap_seq, s.seq);
            check("snap_ch1", snap_ch1, s.c1);
            check("snap_ch2", snap_ch2, s.c2);
            check("snap_ch3", snap_ch3, s.c3);
            check("snap_ch4", snap_ch4, s.c4);
            check("snap_edge", mon_edge, s.edge_n);
            check("rise_to_valid_latency", mon_edge - dut_rise, s.lat);
          end
        end
        prev_d = d; prev_m = m; prev_seq = snap_seq; prev_cap = adc_capture;
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b0; enable = 1'b1; period = 16'd0; host_req = 1'b0;
    snap_ack = 1'b0; overrun_clr = 1'b0; auto_ack = 1'b0;
    conv1 = '0; conv2 = '0; conv3 = '0; conv4 = '0;
    @(negedge clk);
    apply_reset();

    // First capture after reset uses the long settle.
    host_req = 1'b1; tick();
    repeat (INIT + 20) tick();
    check("t1_seq", snap_seq, 1);
    snap_ack = 1'b1; tick();

    // Normal capture.
    host_req = 1'b1; tick();
    repeat (SETTLE + 20) tick();
    snap_ack = 1'b1; tick();

    // Periodic timer, acked by the host.
    auto_ack = 1'b1;
    period = 16'd5000;
    repeat (15010) tick();

    // Host request coinciding with a timer expiry.
    guard = 0;
    while (!(tmr_run && next_exp == m_edge + 1) && guard < 6000) begin
      tick();
      guard++;
    end
    check("t4_timer_align_found", guard < 6000, 1);
    host_req = 1'b1; tick();
    repeat (3400) tick();
    period = 16'd0;
    repeat (10) tick();

    // Overwrite without ack, clear, then ack landing on the snapshot edge.
    auto_ack = 1'b0;
    host_req = 1'b1; tick();
    repeat (SETTLE + 20) tick();
    host_req = 1'b1; tick();
    repeat (SETTLE + 20) tick();
    check("t5_overrun_set", overrun, 1);
    check("t5_valid_held", snap_valid, 1);
    overrun_clr = 1'b1; tick();
    check("t5_overrun_cleared", overrun, 0);
    host_req = 1'b1; tick();
    tick();
    guard = 0;
    while (m_edge + 1 != rise + lim + 1 && guard < 3000) begin
      tick();
      guard++;
    end
    snap_ack = 1'b1; tick();
    check("t5_ack_at_snap_valid", snap_valid, 1);
    check("t5_ack_at_snap_no_ovr", overrun, 0);
    snap_ack = 1'b1; tick();
    check("t5_ack_clears_valid", snap_valid, 0);

    // Reset in the middle of SETTLE; next capture must use the long settle.
    host_req = 1'b1; tick();
    repeat (200) tick();
    #2;
    apply_reset();
    host_req = 1'b1; tick();
    repeat (INIT + 20) tick();
    snap_ack = 1'b1; tick();

    // Randomised traffic.
    auto_ack = 1'b1;
    period = 16'd2000;
    for (int i = 0; i < 20000; i++) begin
      if (enable && $urandom_range(0, 1999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 199) == 0) enable = 1'b1;
      if ($urandom_range(0, 2999) == 0)
        period = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1700, 3000));
      host_req    = ($urandom_range(0, 399) == 0);
      overrun_clr = ($urandom_range(0, 299) == 0);
      tick();
    end

    // Drain any in-flight sequence; every expected snapshot must have appeared.
    enable = 1'b0;
    repeat (INIT + 200) tick();
    check("scoreboard_drained", q_snap.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
